// File: rtl/fwd_hazard_unit.sv
// Operand bypass and load-use hazard unit: tracks in-flight destination tags
// per pipeline stage, forwards from the youngest producer and stalls decode.
module fwd_hazard_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid,
  input  logic                         issue_we,
  input  logic [REG_ADDR_W-1:0]        issue_rd,
  input  logic [NUM_RD-1:0]            rs_used,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rs_addr,
  input  logic [NUM_RD*DATA_W-1:0]     rf_data,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_data,
  input  logic [NUM_STAGES-1:0]        stg_data_vld,
  input  logic                         flush,
  output logic [NUM_RD*DATA_W-1:0]     rs_data_fwd,
  output logic [NUM_RD-1:0]            fwd_hit,
  output logic                         stall,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic [NUM_STAGES-1:0] tag_v_q, tag_v_d;
  logic [REG_ADDR_W-1:0] tag_rd_q [NUM_STAGES];
  logic [REG_ADDR_W-1:0] tag_rd_d [NUM_STAGES];
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_RD-1:0]     hazard;

  // Index 0 is EX (youngest); scanning downward leaves the youngest match.
  always_comb begin
    logic [REG_ADDR_W-1:0] addr;
    logic                  found;
    int                    win;
    rs_data_fwd = rf_data;
    fwd_hit     = '0;
    hazard      = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr  = rs_addr[p*REG_ADDR_W +: REG_ADDR_W];
      found = 1'b0;
      win   = 0;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
        if (tag_v_q[s] && (tag_rd_q[s] == addr) && (addr != '0)) begin
          found = 1'b1;
          win   = s;
        end
      end
      if (found && stg_data_vld[win]) begin
        rs_data_fwd[p*DATA_W +: DATA_W] = stg_data[win*DATA_W +: DATA_W];
        fwd_hit[p]                      = 1'b1;
      end
      hazard[p] = issue_valid & rs_used[p] & found & ~stg_data_vld[win];
    end
  end

  assign stall     = |hazard;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    tag_v_d[0]  = issue_valid & issue_we & (issue_rd != '0) & ~stall & ~flush;
    tag_rd_d[0] = issue_rd;
    for (int s = 1; s < NUM_STAGES; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_rd_d[s] = tag_rd_q[s-1];
    end
    // Flush squashes the instruction currently in EX as well as decode.
    if (flush) tag_v_d[1] = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      tag_v_q     <= tag_v_d;
      stall_cnt_q <= stall_cnt_d;
    end
    for (int s = 0; s < NUM_STAGES; s++) tag_rd_q[s] <= tag_rd_d[s];
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a step table of inputs and expected
// outputs, plus a saturation sequence on a narrow-counter instance.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_rd;
  logic [1:0]  rs_used;
  logic [9:0]  rs_addr;
  logic [63:0] rf_data;
  logic [95:0] stg_data;
  logic [2:0]  stg_data_vld;
  logic        flush;
  logic [63:0] rs_data_fwd, rs_data_fwd_s;
  logic [1:0]  fwd_hit, fwd_hit_s;
  logic        stall, stall_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit u_dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .rs_used(rs_used), .rs_addr(rs_addr), .rf_data(rf_data),
    .stg_data(stg_data), .stg_data_vld(stg_data_vld), .flush(flush),
    .rs_data_fwd(rs_data_fwd), .fwd_hit(fwd_hit), .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .rs_used(rs_used), .rs_addr(rs_addr), .rf_data(rf_data),
    .stg_data(stg_data), .stg_data_vld(stg_data_vld), .flush(flush),
    .rs_data_fwd(rs_data_fwd_s), .fwd_hit(fwd_hit_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        iv;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  used;
    logic [4:0]  a0, a1;
    logic [31:0] dex, dmem, dwb;
    logic [2:0]  vld;
    logic        fl;
    logic        chk;
    logic [31:0] e0, e1;
    logic [1:0]  ehit;
    logic        estall;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic iv, logic we, logic [4:0] rd, logic [1:0] used,
                              logic [4:0] a0, logic [4:0] a1, logic [31:0] dex, logic [31:0] dmem,
                              logic [31:0] dwb, logic [2:0] vld, logic fl, logic chk,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] ehit,
                              logic estall, logic [15:0] ecnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.we = we; v.rd = rd; v.used = used; v.a0 = a0; v.a1 = a1;
    v.dex = dex; v.dmem = dmem; v.dwb = dwb; v.vld = vld; v.fl = fl; v.chk = chk;
    v.e0 = e0; v.e1 = e1; v.ehit = ehit; v.estall = estall; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(string name, int step, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n        = v.rst;
    issue_valid  = v.iv;
    issue_we     = v.we;
    issue_rd     = v.rd;
    rs_used      = v.used;
    rs_addr      = {v.a1, v.a0};
    rf_data      = {32'h2000_0000 | {27'd0, v.a1}, 32'h1000_0000 | {27'd0, v.a0}};
    stg_data     = {v.dwb, v.dmem, v.dex};
    stg_data_vld = v.vld;
    flush        = v.fl;
  endtask

  // Continuous self-dependent hazard: decode writes and reads r3 with no
  // stage ever ready, giving a 4-cycle pattern of one issue then three stalls.
  task automatic sat_cycles(int start, int n);
    for (int i = start; i < start + n; i++) begin
      #1;
      check("sat_stall", 100 + i, {31'd0, stall}, {31'd0, (i % 4) != 0});
      check("sat_stall_narrow", 100 + i, {31'd0, stall_s}, {31'd0, (i % 4) != 0});
      check("sat_hit", 100 + i, {30'd0, fwd_hit_s}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t sv;
    // reset, then reset-state check
    vecs.push_back(mk(0,0,0,0,2'b00,0,0, 0,0,0,3'b000,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,2'b00,5,0, 0,0,0,3'b111,0,1, 32'h1000_0005,32'h2000_0000,2'b00,0,0));
    // EX forward
    vecs.push_back(mk(1,1,1,5,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,0));
    vecs.push_back(mk(1,0,0,0,2'b01,5,0, 32'h1234,0,0,3'b111,0,1, 32'h1234,32'h2000_0000,2'b01,0,0));
    // youngest-wins priority, then same value from MEM on both ports
    vecs.push_back(mk(1,1,1,7,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,0));
    vecs.push_back(mk(1,1,1,7,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,0));
    vecs.push_back(mk(1,0,0,0,2'b01,7,0, 32'hBBBB,32'hAAAA,0,3'b111,0,1, 32'hBBBB,32'h2000_0000,2'b01,0,0));
    vecs.push_back(mk(1,0,0,0,2'b11,7,7, 32'hCCCC,32'hBBBB,32'hAAAA,3'b111,0,1, 32'hBBBB,32'hBBBB,2'b11,0,0));
    vecs.push_back(mk(1,0,0,0,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,0));
    // load-use: one stall cycle, then forward from MEM
    vecs.push_back(mk(1,1,1,3,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,0));
    vecs.push_back(mk(1,1,0,0,2'b01,3,0, 0,0,0,3'b110,0,1, 32'h1000_0003,32'h2000_0000,2'b00,1,0));
    vecs.push_back(mk(1,1,0,0,2'b01,3,0, 0,32'h3333,0,3'b111,0,1, 32'h3333,32'h2000_0000,2'b01,0,1));
    // load-use with operand unused: no stall
    vecs.push_back(mk(1,1,1,3,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,1,0,0,2'b00,3,0, 32'h5555,0,0,3'b110,0,1, 32'h1000_0003,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,0,0,0,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    // r0 writer never forwards
    vecs.push_back(mk(1,1,1,0,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,0,0,0,2'b11,0,0, 32'hDEAD,32'hDEAD,32'hDEAD,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    // WB write-through on port 1
    vecs.push_back(mk(1,1,1,9,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,0,0,0,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,0,0,0,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,0,0,0,2'b10,0,9, 0,0,32'h9999,3'b111,0,1, 32'h1000_0000,32'h9999,2'b10,0,1));
    // flush during load-use stall
    vecs.push_back(mk(1,1,1,4,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,1,0,0,2'b01,4,0, 0,0,0,3'b110,1,1, 32'h1000_0004,32'h2000_0000,2'b00,1,1));
    vecs.push_back(mk(1,1,0,0,2'b01,4,0, 0,0,0,3'b110,0,1, 32'h1000_0004,32'h2000_0000,2'b00,0,1));
    // reset during an active stall
    vecs.push_back(mk(1,1,1,6,2'b00,0,0, 0,0,0,3'b111,0,1, 32'h1000_0000,32'h2000_0000,2'b00,0,1));
    vecs.push_back(mk(1,1,0,0,2'b01,6,0, 0,0,0,3'b110,0,1, 32'h1000_0006,32'h2000_0000,2'b00,1,1));
    vecs.push_back(mk(0,1,0,0,2'b01,6,0, 0,0,0,3'b100,0,1, 32'h1000_0006,32'h2000_0000,2'b00,1,2));
    vecs.push_back(mk(1,1,0,0,2'b01,6,0, 0,0,0,3'b100,0,1, 32'h1000_0006,32'h2000_0000,2'b00,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        check("fwd0", i, rs_data_fwd[31:0], vecs[i].e0);
        check("fwd1", i, rs_data_fwd[63:32], vecs[i].e1);
        check("hit", i, {30'd0, fwd_hit}, {30'd0, vecs[i].ehit});
        check("stall", i, {31'd0, stall}, {31'd0, vecs[i].estall});
        check("stall_cnt", i, {16'd0, stall_cnt}, {16'd0, vecs[i].ecnt});
      end
      @(posedge clk);
      #1;
    end

    // counters were cleared by the mid-stall reset above
    sv = mk(1,1,1,3,2'b01,3,0, 0,0,0,3'b000,0,1, 0,0,0,0,0);
    drive(sv);
    sat_cycles(0, 20);
    check("cnt_after20", 200, {16'd0, stall_cnt}, 32'd15);
    check("cnt_narrow_after20", 201, {28'd0, stall_cnt_s}, 32'd15);
    sat_cycles(20, 8);
    check("cnt_after28", 202, {16'd0, stall_cnt}, 32'd21);
    check("cnt_narrow_saturated", 203, {28'd0, stall_cnt_s}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single write-back/read-port bypass compare. It tracks in-flight destination registers through a NUM_STAGES-deep internal tag pipeline (stage 1 = EX, youngest; stage NUM_STAGES = WB).
- For NUM_RD decode read ports it forwards data from the youngest matching producer.
- It detects load-use hazards, drives a stall, and supports flush.
- Sits between the register file read ports and the decode/EX pipeline register.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register address width
NUM_RD, 2, number of decode read ports (>=1)
NUM_STAGES, 3, tracked producer stages (>=2)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
issue_valid  input  1  decode holds a valid instruction
issue_we  input  1  instruction writes a register
issue_rd  input  REG_ADDR_W  destination register
rs_used  input  NUM_RD  per-port: operand actually consumed
rs_addr  input  NUM_RD*REG_ADDR_W  read addresses, port p at [p*REG_ADDR_W +: REG_ADDR_W]
rf_data  input  NUM_RD*DATA_W  register-file read data per port
stg_data  input  NUM_STAGES*DATA_W  result data per stage s (slice s-1)
stg_data_vld  input  NUM_STAGES  result available at stage s (0 for a load still in EX)
flush  input  1  squash decode and EX
rs_data_fwd  output  NUM_RD*DATA_W  forwarded operands
fwd_hit  output  NUM_RD  port p took bypass data
stall  output  1  hold decode, insert bubble
stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Tag per stage s: {v, rd}. v=1 only if the producer was issued with issue_valid & issue_we & issue_rd!=0. Tags are the only state besides stall_cnt.
- Reset (rst_n=0 at posedge): all tags v=0, stall_cnt=0. Outputs are consequently: stall=0, fwd_hit=0, rs_data_fwd=rf_data. Reset overrides flush and issue the same cycle.
- Normal advance each posedge, no flush, no stall:
  - tag[1] <= issue tag.
  - tag[s+1] <= tag[s].
  - tag[NUM_STAGES] retires (register file written that cycle).
- Stall cycle: tag[1] <= bubble (v=0); tags 2..NUM_STAGES still shift from the stage below. Older stages always drain.
- Flush: tag[1] <= bubble and tag[2] <= bubble (EX instruction squashed); tags 3..NUM_STAGES shift normally. Flush has priority over stall.
- Match (combinational): port p matches stage s when tag[s].v & tag[s].rd == rs_addr_p & rs_addr_p != 0.
- Selection: youngest matching stage (lowest s) wins. Address 0 never forwards and always returns rf_data.
- Forwarding:
  - Winner s with stg_data_vld[s]=1: rs_data_fwd_p = stg_data[s], fwd_hit[p]=1.
  - No match: rs_data_fwd_p = rf_data_p, fwd_hit[p]=0.
  - Stage NUM_STAGES forwarding gives same-cycle write-through.
- Hazard: a port hazards when issue_valid & rs_used[p] & a winner exists & stg_data_vld[winner]=0.
  - stall = OR over ports; combinational, zero latency.
  - An older valid match never overrides a younger not-ready match.
- Output during hazard: fwd_hit[p]=0 and rs_data_fwd_p = rf_data_p for a stalled port; the value is don't-care to the pipeline.
- Decode holds the same instruction while stall=1. The unit re-evaluates each cycle and stall drops once the producer reaches a stage with stg_data_vld=1.
- stall_cnt increments by 1 at each posedge where stall=1 & flush=0 & rst_n=1. It saturates at 2^CNT_W-1 with no wrap.
- Multiple ports may hit different or identical stages independently.
- Duplicate rd in several stages is legal; the youngest wins.

Test Plan:
1. EX forward: issue rd=5 (we=1); next cycle rs_addr0=5, stg_data[EX]=0x1234, vld=1 -> rs_data_fwd0=0x1234, fwd_hit[0]=1, stall=0.
2. Priority: rd=7 in MEM (0xAAAA) and rd=7 in EX (0xBBBB), both valid -> port0=0xBBBB. Next cycle, with no new writer -> 0xBBBB now comes from the MEM slice.
3. Load-use: load rd=3 in EX with stg_data_vld[1]=0, decode reads r3 with rs_used=1:
   - stall=1 for exactly 1 cycle; tag[1] becomes a bubble.
   - Next cycle the load is in MEM with vld=1 -> stall=0, forwarded value correct, stall_cnt=1.
   - Same case with rs_used=0 -> stall=0.
4. r0 and write-through:
   - issue_rd=0, we=1, then read r0 -> no hit, rf_data returned.
   - rd=9 in WB, rs_addr1=9 -> stg_data[WB] forwarded (write-through).
5. Flush: load rd=4 in EX causing stall, flush=1 same cycle -> next cycle tags 1-2 invalid, r4 read returns rf_data, stall=0, stall_cnt unchanged.
6. Reset mid-stall and saturation:
   - rst_n=0 during an active stall -> after the edge, stall=0, all fwd_hit=0, stall_cnt=0.
   - With CNT_W=4, hold a hazard for 20 cycles -> stall_cnt=15.
